mem_stage_lsu: RTL and testbench

Parametrised load/store unit that replaces the single-cycle, word-only memory stage path of the 5-stage RISC-V core. Supports byte, halfword and word loads and stores with sign/zero extension. Drives a request/grant/rvalid data-memory handshake through a small FSM and stalls the pipeline while an access is outstanding. A watchdog aborts accesses that are never granted or answered. Sits between Execute (address, operands) and Write-Back (load data).

---
 rtl/mem_stage_lsu_pkg.sv | 83 ++++++++
 rtl/mem_stage_lsu_if.sv | 37 +++
 rtl/mem_stage_lsu_load_align.sv | 27 ++
 rtl/mem_stage_lsu.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and lane helpers for the memory-stage load/store unit.
// Operator encoding, FSM state constants and byte-lane/alignment functions.
package mem_stage_lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } load_store_func_code;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } lsu_size_e;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t IDLE = 2'd0;
  localparam lsu_state_t REQ  = 2'd1;
  localparam lsu_state_t WAIT = 2'd2;

  function automatic logic is_store(load_store_func_code op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic lsu_size_e op_size(load_store_func_code op);
    lsu_size_e sz;
    case (op)
      LB, LBU, SB: sz = SzByte;
      LH, LHU, SH: sz = SzHalf;
      default:     sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(load_store_func_code op, logic [1:0] off);
    logic mis;
    case (op_size(op))
      SzHalf:  mis = off[0];
      SzWord:  mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Force the in-word offset to the natural alignment of the access size.
  function automatic logic [1:0] align_offset(load_store_func_code op, logic [1:0] off);
    logic [1:0] res;
    case (op_size(op))
      SzHalf:  res = {off[1], 1'b0};
      SzWord:  res = 2'b00;
      default: res = off;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_enable(load_store_func_code op, logic [1:0] off);
    logic [3:0] be;
    case (op_size(op))
      SzByte:  be = 4'b0001 << off;
      SzHalf:  be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes; byte enables pick the live one.
  function automatic logic [31:0] store_lanes(load_store_func_code op, logic [31:0] data);
    logic [31:0] res;
    case (op_size(op))
      SzByte:  res = {4{data[7:0]}};
      SzHalf:  res = {2{data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/rvalid bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  data_req_op;
  logic [ADDR_WIDTH-1:0] data_addr_op;
  logic                  data_we_op;
  logic [3:0]            data_be_op;
  logic [31:0]           data_wdata_op;
  logic                  data_gnt_i;
  logic                  data_rvalid_i;
  logic [31:0]           data_rdata_i;

  modport master (
    output data_req_op,
    output data_addr_op,
    output data_we_op,
    output data_be_op,
    output data_wdata_op,
    input  data_gnt_i,
    input  data_rvalid_i,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_op,
    input  data_addr_op,
    input  data_we_op,
    input  data_be_op,
    input  data_wdata_op,
    output data_gnt_i,
    output data_rvalid_i,
    output data_rdata_i
  );

endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load alignment: selects the byte/halfword lane of the raw memory word and
// sign- or zero-extends it according to the load operator.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  load_store_func_code operator_i,
  input  logic [1:0]          offset_i,
  input  logic [31:0]         rdata_i,
  output logic [31:0]         result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
    case (operator_i)
      LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result_o = {24'd0, byte_sel};
      LH:      result_o = {{16{half_sel[15]}}, half_sel};
      LHU:     result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: byte/half/word loads and stores over a req/gnt/rvalid bus with
// pipeline stall and watchdog abort. Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lsu_en_ip,
  input  logic                  alu_valid_ip,
  input  load_store_func_code   lsu_operator_ip,
  input  logic [ADDR_WIDTH-1:0] mem_addr_ip,
  input  logic [31:0]           store_data_ip,
  mem_stage_lsu_if.master       data_bus,
  output logic [31:0]           load_mem_data_op,
  output logic                  load_valid_op,
  output logic                  store_done_op,
  output logic                  lsu_busy_op,
  output logic                  misaligned_op,
  output logic                  bus_err_op
);

  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned     CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax    =
      CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  load_store_func_code   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic [31:0]           load_data_q;
  logic [31:0]           load_result;
  logic                  load_valid_q, store_done_q, bus_err_q;
  logic                  req_present, misaligned, accept;
  logic                  complete, abort, timeout_hit;
  logic [1:0]            acc_off;

  assign req_present = lsu_en_ip & alu_valid_ip & (state_q == IDLE);
  assign acc_off     = align_offset(lsu_operator_ip, mem_addr_ip[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = req_present & is_misaligned(lsu_operator_ip, mem_addr_ip[1:0]);
  assign accept     = req_present & ~misaligned;
`else
  assign misaligned = 1'b0;
  assign accept     = req_present;
`endif

  assign timeout_hit = TimeoutEn && (cnt_q == CntMax);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (data_bus.data_gnt_i) begin
          cnt_d = '0;
          if (data_bus.data_rvalid_i) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (data_bus.data_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured once at accept so the bus stays stable while ungranted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q    <= LB;
      addr_q  <= '0;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      op_q    <= lsu_operator_ip;
      addr_q  <= {mem_addr_ip[ADDR_WIDTH-1:2], 2'b00};
      off_q   <= acc_off;
      be_q    <= byte_enable(lsu_operator_ip, acc_off);
      wdata_q <= store_lanes(lsu_operator_ip, store_data_ip);
      we_q    <= is_store(lsu_operator_ip);
    end
  end

  mem_stage_lsu_load_align u_load_align (
    .operator_i (op_q),
    .offset_i   (off_q),
    .rdata_i    (data_bus.data_rdata_i),
    .result_o   (load_result)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= complete & ~we_q;
      store_done_q <= complete & we_q;
      bus_err_q    <= abort;
      if (complete && !we_q) begin
        load_data_q <= load_result;
      end
    end
  end

  assign data_bus.data_req_op   = (state_q == REQ);
  assign data_bus.data_addr_op  = addr_q;
  assign data_bus.data_we_op    = we_q;
  assign data_bus.data_be_op    = be_q;
  assign data_bus.data_wdata_op = wdata_q;

  assign load_mem_data_op = load_data_q;
  assign load_valid_op    = load_valid_q;
  assign store_done_op    = store_done_q;
  assign bus_err_op       = bus_err_q;
  assign misaligned_op    = misaligned;
  assign lsu_busy_op      = accept | (state_q != IDLE);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table of zero-wait accesses plus
// hand-written stall, timeout, back-to-back, misalignment and reset sequences.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                lsu_en;
  logic                alu_valid;
  load_store_func_code op;
  logic [31:0]         addr;
  logic [31:0]         sdata;
  logic [31:0]         load_data;
  logic                load_valid, store_done, busy, misal, bus_err;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_load = 32'h0;

  mem_stage_lsu_if #(.ADDR_WIDTH(32)) bus ();

  mem_stage_lsu #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .lsu_en_ip        (lsu_en),
    .alu_valid_ip     (alu_valid),
    .lsu_operator_ip  (op),
    .mem_addr_ip      (addr),
    .store_data_ip    (sdata),
    .data_bus         (bus),
    .load_mem_data_op (load_data),
    .load_valid_op    (load_valid),
    .store_done_op    (store_done),
    .lsu_busy_op      (busy),
    .misaligned_op    (misal),
    .bus_err_op       (bus_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    load_store_func_code op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        st;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    lsu_en            = 1'b0;
    alu_valid         = 1'b0;
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = 32'h0;
  endtask

  task automatic present(input load_store_func_code o, input logic [31:0] a, input logic [31:0] d);
    lsu_en    = 1'b1;
    alu_valid = 1'b1;
    op        = o;
    addr      = a;
    sdata     = d;
  endtask

  task automatic withdraw();
    lsu_en    = 1'b0;
    alu_valid = 1'b0;
    addr      = 32'hFFFF_FFFF;
    sdata     = 32'h5A5A_5A5A;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    string t;
    t = $sformatf("row%0d", idx);
    next_cycle(); present(v.op, v.addr, v.sdata); settle();
    chk({t, " busy_accept"}, 32'(busy), 1);
    chk({t, " req_accept"}, 32'(bus.data_req_op), 0);
    next_cycle(); withdraw(); bus.data_gnt_i = 1'b1; settle();
    chk({t, " req"}, 32'(bus.data_req_op), 1);
    chk({t, " addr"}, bus.data_addr_op, v.exp_addr);
    chk({t, " we"}, 32'(bus.data_we_op), 32'(v.st));
    if (v.st) begin
      chk({t, " be"}, 32'(bus.data_be_op), 32'(v.exp_be));
      chk({t, " wdata"}, bus.data_wdata_op, v.exp_wdata);
    end
    next_cycle(); bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = v.rdata;
    settle();
    chk({t, " req_wait"}, 32'(bus.data_req_op), 0);
    chk({t, " busy_wait"}, 32'(busy), 1);
    chk({t, " early_valid"}, 32'(load_valid), 0);
    next_cycle(); bus.data_rvalid_i = 1'b0; bus.data_rdata_i = 32'h0; settle();
    if (!v.st) last_load = v.exp_load;
    chk({t, " load_valid"}, 32'(load_valid), 32'(!v.st));
    chk({t, " store_done"}, 32'(store_done), 32'(v.st));
    chk({t, " load_data"}, load_data, last_load);
    chk({t, " busy_done"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{LB,  32'h103, 32'h0,        32'h80112233, 1'b0, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{LBU, 32'h103, 32'h0,        32'h80112233, 1'b0, 32'h100, 4'h8, 32'h0,        32'h00000080};
    vecs[3]  = '{LH,  32'h102, 32'h0,        32'h80112233, 1'b0, 32'h100, 4'hC, 32'h0,        32'hFFFF8011};
    vecs[4]  = '{LHU, 32'h100, 32'h0,        32'h80112233, 1'b0, 32'h100, 4'h3, 32'h0,        32'h00002233};
    vecs[5]  = '{LB,  32'h101, 32'h0,        32'h80112233, 1'b0, 32'h100, 4'h2, 32'h0,        32'h00000022};
    vecs[6]  = '{LH,  32'h200, 32'h0,        32'h0000F00F, 1'b0, 32'h200, 4'h3, 32'h0,        32'hFFFFF00F};
    vecs[7]  = '{SH,  32'h102, 32'h0000ABCD, 32'h0,        1'b1, 32'h100, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[8]  = '{SB,  32'h201, 32'h123456A5, 32'h0,        1'b1, 32'h200, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{SW,  32'h304, 32'hCAFEF00D, 32'h0,        1'b1, 32'h304, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{LW,  32'h304, 32'h0,        32'h13572468, 1'b0, 32'h304, 4'hF, 32'h0,        32'h13572468};
    vecs[11] = '{SB,  32'h003, 32'h00000077, 32'h0,        1'b1, 32'h000, 4'h8, 32'h77777777, 32'h0};

    drive_idle();
    op    = LB;
    addr  = 32'h0;
    sdata = 32'h0;
    #1 reset = 1'b0;
    #2;
    chk("rst req", 32'(bus.data_req_op), 0);
    chk("rst addr", bus.data_addr_op, 0);
    chk("rst we", 32'(bus.data_we_op), 0);
    chk("rst be", 32'(bus.data_be_op), 0);
    chk("rst wdata", bus.data_wdata_op, 0);
    chk("rst load_data", load_data, 0);
    chk("rst load_valid", 32'(load_valid), 0);
    chk("rst store_done", 32'(store_done), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst misaligned", 32'(misal), 0);
    chk("rst bus_err", 32'(bus_err), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    foreach (vecs[i]) run_row(i, vecs[i]);

    // Grant withheld for five cycles: request must stay stable.
    next_cycle(); present(LW, 32'h140, 32'h0); settle();
    for (int i = 0; i < 5; i++) begin
      next_cycle(); withdraw(); settle();
      chk($sformatf("stall%0d req", i), 32'(bus.data_req_op), 1);
      chk($sformatf("stall%0d addr", i), bus.data_addr_op, 32'h140);
      chk($sformatf("stall%0d be", i), 32'(bus.data_be_op), 32'hF);
      chk($sformatf("stall%0d busy", i), 32'(busy), 1);
    end
    next_cycle(); bus.data_gnt_i = 1'b1; settle();
    chk("stall req_at_gnt", 32'(bus.data_req_op), 1);
    next_cycle(); bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i = 32'h13579BDF; settle();
    chk("stall req_wait", 32'(bus.data_req_op), 0);
    next_cycle(); drive_idle(); settle();
    last_load = 32'h13579BDF;
    chk("stall load_valid", 32'(load_valid), 1);
    chk("stall load_data", load_data, last_load);

    // No grant at all: abort 8 cycles after REQ entry.
    next_cycle(); present(LB, 32'h10, 32'h0); settle();
    for (int i = 1; i <= 8; i++) begin
      next_cycle(); withdraw(); settle();
      chk($sformatf("to_req%0d bus_err", i), 32'(bus_err), 0);
      chk($sformatf("to_req%0d busy", i), 32'(busy), 1);
    end
    next_cycle(); settle();
    chk("to_req bus_err", 32'(bus_err), 1);
    chk("to_req busy", 32'(busy), 0);
    chk("to_req req", 32'(bus.data_req_op), 0);
    chk("to_req load_valid", 32'(load_valid), 0);
    chk("to_req load_data", load_data, last_load);
    next_cycle(); settle();
    chk("to_req bus_err_pulse", 32'(bus_err), 0);

    // Granted but never answered: counter restarts at grant.
    next_cycle(); present(LW, 32'h20, 32'h0); settle();
    next_cycle(); withdraw(); bus.data_gnt_i = 1'b1; settle();
    chk("to_wait req", 32'(bus.data_req_op), 1);
    for (int i = 2; i <= 9; i++) begin
      next_cycle(); bus.data_gnt_i = 1'b0; settle();
      chk($sformatf("to_wait%0d bus_err", i), 32'(bus_err), 0);
    end
    next_cycle(); settle();
    chk("to_wait bus_err", 32'(bus_err), 1);
    chk("to_wait busy", 32'(busy), 0);
    chk("to_wait load_valid", 32'(load_valid), 0);

    // gnt and rvalid together in REQ, then a store accepted in the result cycle.
    next_cycle(); present(LW, 32'h20, 32'h0); settle();
    next_cycle(); withdraw(); bus.data_gnt_i = 1'b1; bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i = 32'h0BADF00D; settle();
    chk("fast req", 32'(bus.data_req_op), 1);
    next_cycle(); drive_idle(); present(SW, 32'h40, 32'h11223344); settle();
    last_load = 32'h0BADF00D;
    chk("fast load_valid", 32'(load_valid), 1);
    chk("fast load_data", load_data, last_load);
    chk("b2b busy", 32'(busy), 1);
    next_cycle(); withdraw(); bus.data_gnt_i = 1'b1; bus.data_rvalid_i = 1'b1; settle();
    chk("b2b req", 32'(bus.data_req_op), 1);
    chk("b2b addr", bus.data_addr_op, 32'h40);
    chk("b2b we", 32'(bus.data_we_op), 1);
    chk("b2b wdata", bus.data_wdata_op, 32'h11223344);
    next_cycle(); drive_idle(); settle();
    chk("b2b store_done", 32'(store_done), 1);
    chk("b2b load_valid", 32'(load_valid), 0);
    chk("b2b busy_done", 32'(busy), 0);

    // Responses in IDLE are ignored.
    next_cycle(); bus.data_gnt_i = 1'b1; bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i = 32'hFFFF_FFFF; settle();
    chk("idle req", 32'(bus.data_req_op), 0);
    next_cycle(); drive_idle(); settle();
    chk("idle load_valid", 32'(load_valid), 0);
    chk("idle store_done", 32'(store_done), 0);
    chk("idle load_data", load_data, last_load);

    // Misaligned word load.
    next_cycle(); present(LW, 32'h102, 32'h0); settle();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis pulse", 32'(misal), 1);
    chk("mis busy", 32'(busy), 0);
    next_cycle(); withdraw(); settle();
    chk("mis no_req", 32'(bus.data_req_op), 0);
    chk("mis pulse_end", 32'(misal), 0);
    chk("mis busy_after", 32'(busy), 0);
`else
    chk("mis pulse", 32'(misal), 0);
    chk("mis busy", 32'(busy), 1);
    next_cycle(); withdraw(); bus.data_gnt_i = 1'b1; bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i = 32'hA5A55A5A; settle();
    chk("mis req", 32'(bus.data_req_op), 1);
    chk("mis addr", bus.data_addr_op, 32'h100);
    chk("mis be", 32'(bus.data_be_op), 32'hF);
    next_cycle(); drive_idle(); settle();
    last_load = 32'hA5A55A5A;
    chk("mis load_valid", 32'(load_valid), 1);
    chk("mis load_data", load_data, last_load);
`endif

    // Reset in the middle of an access.
    next_cycle(); present(LW, 32'h80, 32'h0); settle();
    next_cycle(); withdraw(); settle();
    chk("rstmid req_before", 32'(bus.data_req_op), 1);
    #1 reset = 1'b0;
    #1;
    chk("rstmid req", 32'(bus.data_req_op), 0);
    chk("rstmid busy", 32'(busy), 0);
    chk("rstmid load_data", load_data, 0);
    next_cycle(); reset = 1'b1; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h12345678;
    settle();
    next_cycle(); drive_idle(); settle();
    chk("rstmid load_valid", 32'(load_valid), 0);
    chk("rstmid load_data_after", load_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
